result_packer: RTL and testbench

RESULT_PACKER -- requirements
Module: result_packer

---
 rtl/calculator_pkg.sv | 28 ++
 rtl/word_fifo.sv | 65 ++++++
 rtl/result_packer.sv | 123 ++++++++++++
 tb/tb_result_packer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/calculator_pkg.sv
// Shared calculator parameters, result-packer state encoding and the packed FIFO entry layout.
package calculator_pkg;

    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 64;
    localparam int PACK_DEPTH    = 2;
    localparam int ENTRY_W       = MEM_WORD_SIZE + 2;

    localparam logic [1:0] FULL_CNT  = 2'd2;
    localparam logic [1:0] EMPTY_CNT = 2'd0;

    typedef enum logic [1:0] {
        A_EMPTY = 2'b00,
        A_UPPER = 2'b01,
        A_LOWER = 2'b10
    } pack_state_t;

    // FIFO entry layout: {upper carry, lower carry, upper half, lower half}
    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic [DATA_W-1:0] upper,
        input logic [DATA_W-1:0] lower,
        input logic              carry_up,
        input logic              carry_lo
    );
        return {carry_up, carry_lo, upper, lower};
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Two-entry synchronous FIFO holding packed words plus their carry flags.
// A push into a full FIFO is accepted only when a pop frees the head slot on the same edge.
module word_fifo
    import calculator_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [ENTRY_W-1:0] data_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic [1:0]         count_o,
    output logic               full_o
);

    logic [ENTRY_W-1:0] mem_r [PACK_DEPTH];
    logic               wr_ptr_r;
    logic               rd_ptr_r;
    logic [1:0]         count_r;
    logic               push_s;
    logic               pop_s;

    // Qualify requests against current occupancy.
    always_comb begin
        pop_s  = pop_i && (count_r != EMPTY_CNT);
        push_s = push_i && ((count_r != FULL_CNT) || pop_s);
    end

    // Storage, 1-bit wrapping pointers and occupancy counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < PACK_DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= EMPTY_CNT;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= data_i;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head is forced to zero while empty so stale entries never leak out.
    always_comb begin
        if (count_r != EMPTY_CNT) begin
            head_o = mem_r[rd_ptr_r];
        end else begin
            head_o = {ENTRY_W{1'b0}};
        end
        count_o = count_r;
        full_o  = (count_r == FULL_CNT);
    end

endmodule

// File: rtl/result_packer.sv
// Assembles two 32-bit adder halves (any order) into a 64-bit word with carries and queues it
// in a 2-entry FIFO; same-half rewrites and overflow drops raise a sticky error.
module result_packer
    import calculator_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [DATA_W-1:0]        sum_i,
    input  logic                     carry_i,
    input  logic                     buffer_write,
    input  logic                     buffer_control,
    output logic [MEM_WORD_SIZE-1:0] buff_result,
    output logic                     buff_valid,
    input  logic                     buff_ready,
    output logic [1:0]               ovf_o,
    output logic [1:0]               count_o,
    output logic                     full_o,
    output logic                     err_o
);

    pack_state_t        state_r;
    logic [DATA_W-1:0]  upper_r;
    logic [DATA_W-1:0]  lower_r;
    logic               carry_up_r;
    logic               carry_lo_r;
    logic               err_r;

    logic               push_s;
    logic               pop_s;
    logic               overwrite_s;
    logic               drop_s;
    logic               full_s;
    logic [1:0]         count_s;
    logic [ENTRY_W-1:0] entry_s;
    logic [ENTRY_W-1:0] head_s;

    // Decode the incoming half against the held half: complete, overwrite or start.
    always_comb begin
        push_s      = 1'b0;
        overwrite_s = 1'b0;
        entry_s     = pack_entry(upper_r, sum_i, carry_up_r, carry_i);
        if (!buffer_write) begin
            case (state_r)
                A_UPPER: begin
                    if (buffer_control) begin
                        overwrite_s = 1'b1;
                    end else begin
                        push_s  = 1'b1;
                        entry_s = pack_entry(upper_r, sum_i, carry_up_r, carry_i);
                    end
                end
                A_LOWER: begin
                    if (!buffer_control) begin
                        overwrite_s = 1'b1;
                    end else begin
                        push_s  = 1'b1;
                        entry_s = pack_entry(sum_i, lower_r, carry_i, carry_lo_r);
                    end
                end
                default: begin
                    push_s = 1'b0;
                end
            endcase
        end else begin
            push_s = 1'b0;
        end
        pop_s  = buff_ready && buff_valid;
        drop_s = push_s && full_s && !pop_s;
    end

    // Assembly FSM, held halves and sticky error flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= A_EMPTY;
            upper_r    <= {DATA_W{1'b0}};
            lower_r    <= {DATA_W{1'b0}};
            carry_up_r <= 1'b0;
            carry_lo_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            if (!buffer_write) begin
                if (buffer_control) begin
                    upper_r    <= sum_i;
                    carry_up_r <= carry_i;
                end else begin
                    lower_r    <= sum_i;
                    carry_lo_r <= carry_i;
                end
                case (state_r)
                    A_EMPTY: state_r <= buffer_control ? A_UPPER : A_LOWER;
                    A_UPPER: state_r <= buffer_control ? A_UPPER : A_EMPTY;
                    A_LOWER: state_r <= buffer_control ? A_EMPTY : A_LOWER;
                    default: state_r <= A_EMPTY;
                endcase
            end
            if (overwrite_s || drop_s) begin
                err_r <= 1'b1;
            end
        end
    end

    word_fifo u_word_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (entry_s),
        .head_o  (head_s),
        .count_o (count_s),
        .full_o  (full_s)
    );

    // Outputs come straight from FIFO registers and the error register.
    always_comb begin
        buff_result = head_s[MEM_WORD_SIZE-1:0];
        ovf_o       = head_s[ENTRY_W-1:MEM_WORD_SIZE];
        buff_valid  = (count_s != EMPTY_CNT);
        count_o     = count_s;
        full_o      = full_s;
        err_o       = err_r;
    end

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: directed scenarios then random traffic vs a queue model.
module tb_result_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] sum_i;
    logic        carry_i;
    logic        buffer_write;
    logic        buffer_control;
    logic [63:0] buff_result;
    logic        buff_valid;
    logic        buff_ready;
    logic [1:0]  ovf_o;
    logic [1:0]  count_o;
    logic        full_o;
    logic        err_o;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: which half is pending plus a queue of completed words.
    int          m_state;   // 0 nothing held, 1 upper held, 2 lower held
    logic [31:0] m_up, m_lo;
    logic        m_cu, m_cl;
    logic [63:0] q_word[$];
    logic [1:0]  q_ovf[$];
    logic        m_err;

    result_packer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sum_i          (sum_i),
        .carry_i        (carry_i),
        .buffer_write   (buffer_write),
        .buffer_control (buffer_control),
        .buff_result    (buff_result),
        .buff_valid     (buff_valid),
        .buff_ready     (buff_ready),
        .ovf_o          (ovf_o),
        .count_o        (count_o),
        .full_o         (full_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_up = 32'h0; m_lo = 32'h0; m_cu = 1'b0; m_cl = 1'b0;
        q_word.delete();
        q_ovf.delete();
        m_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        bit ne;
        ne = (q_word.size() > 0);
        chk({tag, ".valid"}, {63'h0, buff_valid}, {63'h0, ne});
        chk({tag, ".result"}, buff_result, ne ? q_word[0] : 64'h0);
        chk({tag, ".ovf"}, {62'h0, ovf_o}, ne ? {62'h0, q_ovf[0]} : 64'h0);
        chk({tag, ".count"}, {62'h0, count_o}, 64'(q_word.size()));
        chk({tag, ".full"}, {63'h0, full_o}, {63'h0, (q_word.size() == 2)});
        chk({tag, ".err"}, {63'h0, err_o}, {63'h0, m_err});
    endtask

    // One clock: drive inputs, advance the model, then check on the falling edge.
    task automatic step(input bit we, input bit ctl, input logic [31:0] d, input bit c, input bit rdy);
        bit pop, push, full_before;
        logic [63:0] w;
        logic [1:0]  o;
        buffer_write   = ~we;
        buffer_control = ctl;
        sum_i          = d;
        carry_i        = c;
        buff_ready     = rdy;
        full_before = (q_word.size() == 2);
        pop  = rdy && (q_word.size() > 0);
        push = 1'b0;
        w = 64'h0; o = 2'b00;
        if (we) begin
            if (ctl) begin m_up = d; m_cu = c; end
            else     begin m_lo = d; m_cl = c; end
            if (m_state == 0) begin
                m_state = ctl ? 1 : 2;
            end else if ((m_state == 1) == ctl) begin
                m_err = 1'b1;
            end else begin
                push = 1'b1;
                w = {m_up, m_lo};
                o = {m_cu, m_cl};
                m_state = 0;
            end
        end
        if (pop) begin
            void'(q_word.pop_front());
            void'(q_ovf.pop_front());
        end
        if (push) begin
            if (full_before && !pop) m_err = 1'b1;
            else begin q_word.push_back(w); q_ovf.push_back(o); end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        buffer_write = 1'b1;
        buff_ready   = 1'b0;
        check_all("step");
    endtask

    task automatic word(input logic [31:0] up, input logic [31:0] lo, input bit cu, input bit cl, input bit rdy);
        step(1'b1, 1'b1, up, cu, 1'b0);
        step(1'b1, 1'b0, lo, cl, rdy);
    endtask

    // Reset pulsed low between edges; outputs must clear without waiting for a clock.
    task automatic pulse_reset();
        #2;
        rst_i = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0;
        buffer_write = 1'b1; buffer_control = 1'b0; sum_i = 32'h0; carry_i = 1'b0; buff_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        check_all("reset");
        rst_i = 1'b1;
        @(negedge clk_i);

        // Basic pack, upper first
        word(32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        chk("basic_word", buff_result, 64'h0000_0003_FFFF_FFFF);
        chk("basic_ovf", {62'h0, ovf_o}, 64'h1);
        chk("basic_count", {62'h0, count_o}, 64'h1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Fill and overflow: A, B stored, C dropped; drain returns A then B
        word(32'hAAAA_0001, 32'hAAAA_0002, 1'b1, 1'b0, 1'b0);
        word(32'hBBBB_0001, 32'hBBBB_0002, 1'b0, 1'b1, 1'b0);
        chk("fill_full", {63'h0, full_o}, 64'h1);
        word(32'hCCCC_0001, 32'hCCCC_0002, 1'b1, 1'b1, 1'b0);
        chk("drop_err", {63'h0, err_o}, 64'h1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("drain_b", buff_result, 64'hBBBB_0001_BBBB_0002);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        pulse_reset();

        // Simultaneous push and pop while full, lower half first for D
        word(32'h1111_0001, 32'h1111_0002, 1'b0, 1'b0, 1'b0);
        word(32'h2222_0001, 32'h2222_0002, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'hDDDD_0002, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'hDDDD_0001, 1'b0, 1'b1);
        chk("pp_count", {62'h0, count_o}, 64'h2);
        chk("pp_err", {63'h0, err_o}, 64'h0);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Same-half overwrite
        step(1'b1, 1'b1, 32'h1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h5, 1'b0, 1'b0);
        chk("ovw_word", buff_result, 64'h0000_0002_0000_0005);
        chk("ovw_err", {63'h0, err_o}, 64'h1);

        // Reset mid-word with one word queued, then restart lower-first
        step(1'b1, 1'b1, 32'h9, 1'b1, 1'b0);
        pulse_reset();
        @(negedge clk_i);
        step(1'b1, 1'b0, 32'h7, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h8, 1'b0, 1'b0);
        chk("rst_word", buff_result, 64'h0000_0008_0000_0007);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Pointer wrap: five push/pop pairs
        for (int i = 0; i < 5; i++) begin
            word($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk("wrap_count", {62'h0, count_o}, 64'h0);

        // Random traffic with periodic reset to clear the sticky error
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 99) begin
                pulse_reset();
                @(negedge clk_i);
            end
            step(($urandom_range(0, 3) != 0), 1'($urandom), $urandom, 1'($urandom),
                 ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
